// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  // Fill bit of the hard-wired zero-register address (all ones).
  localparam logic ZERO_REG = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping to 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             found,
  output logic [PTR_W-1:0] winner,
  output logic [N-1:0]     onehot
);

  logic [PTR_W:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (idx >= (PTR_W + 1)'(N)) idx = idx - (PTR_W + 1)'(N);
      if (!found && eligible[idx[PTR_W-1:0]]) begin
        found                   = 1'b1;
        winner                  = idx[PTR_W-1:0];
        onehot[idx[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; all outputs registered.
// Optional zero-register filter enabled by defining REGFILE_ARB_ZERO_REG_EN.
//
// state | meaning
// IDLE  | no grant issued at the last edge
// WRITE | a grant was issued at the last edge
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

`ifdef REGFILE_ARB_ZERO_REG_EN
  localparam bit ZERO_FILTER = 1'b1;
`else
  localparam bit ZERO_FILTER = 1'b0;
`endif

  arb_state_t          state, state_d;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
  logic [NUM_REQ-1:0]  eligible, onehot, grant_d;
  logic                found, wr_en_d, zero_hit;
  logic [PTR_W-1:0]    winner;
  logic [ADDR_W-1:0]   win_addr, wr_addr_d;
  logic [DATA_W-1:0]   win_data, wr_data_d;

  // Last cycle's grantee is masked so its stale req cannot win twice.
  assign eligible = req & ~grant;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (found),
    .winner   (winner),
    .onehot   (onehot)
  );

  assign win_addr = req_addr[winner*ADDR_W +: ADDR_W];
  assign win_data = req_data[winner*DATA_W +: DATA_W];
  assign zero_hit = ZERO_FILTER && (win_addr == {ADDR_W{ZERO_REG}});

  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    grant_d   = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    case (state)
      IDLE:    if (found)  state_d = WRITE;
      WRITE:   if (!found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (found) begin
      grant_d  = onehot;
      rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      // A zero-register winner is still granted, but nothing is written.
      if (!zero_hit) begin
        wr_en_d   = 1'b1;
        wr_addr_d = win_addr;
        wr_data_d = win_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      grant   <= grant_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= |req;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table plus randomized run against a reference model.
module tb_regfile_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      grant;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .grant    (grant),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  rq;
    logic [AW-1:0] a0;
    logic [N-1:0]  e_grant;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [N-1:0] rq, logic [AW-1:0] a0, logic [N-1:0] g,
                              logic en, logic [AW-1:0] ad, logic [DW-1:0] dt, logic bz);
    vec_t v;
    v.rst = rst; v.rq = rq; v.a0 = a0; v.e_grant = g; v.e_en = en;
    v.e_addr = ad; v.e_data = dt; v.e_busy = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: pointer, last grant, held write address/data.
  int            m_ptr;
  logic [N-1:0]  m_grant;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_busy;

  task automatic model_step(input logic rst, input logic [N-1:0] rq,
                            input logic [N*AW-1:0] ab, input logic [N*DW-1:0] db);
    int w;
    bit filt;
    if (rst) begin
      m_ptr = 0; m_grant = '0; m_en = 0; m_addr = '0; m_data = '0; m_busy = 0;
      return;
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (w < 0 && rq[i] && !m_grant[i]) w = i;
    end
    m_busy = |rq;
    if (w >= 0) begin
      m_grant = '0;
      m_grant[w] = 1'b1;
      m_ptr = (w + 1) % N;
      filt = 0;
`ifdef REGFILE_ARB_ZERO_REG_EN
      filt = (ab[w*AW +: AW] == {AW{1'b1}});
`endif
      m_en = !filt;
      if (!filt) begin
        m_addr = ab[w*AW +: AW];
        m_data = db[w*DW +: DW];
      end
    end else begin
      m_grant = '0;
      m_en = 0;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;

    // Fixed addresses 5,1,2,3 (a0 overridable) and data AA,B1,C2,D3.
    vecs.push_back(mk(1, 4'b0000, 5, 4'b0000, 0, 0, 64'h00, 0));
    vecs.push_back(mk(0, 4'b0001, 5, 4'b0001, 1, 5, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b0000, 5, 4'b0000, 0, 5, 64'hAA, 0));
    vecs.push_back(mk(1, 4'b0000, 5, 4'b0000, 0, 0, 64'h00, 0));
    vecs.push_back(mk(0, 4'b0110, 5, 4'b0010, 1, 1, 64'hB1, 1));
    vecs.push_back(mk(0, 4'b0110, 5, 4'b0100, 1, 2, 64'hC2, 1));
    vecs.push_back(mk(0, 4'b0000, 5, 4'b0000, 0, 2, 64'hC2, 0));
    vecs.push_back(mk(1, 4'b0000, 5, 4'b0000, 0, 0, 64'h00, 0));
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(0, 4'b1111, 5, 4'b0001, 1, 5, 64'hAA, 1));
      vecs.push_back(mk(0, 4'b1111, 5, 4'b0010, 1, 1, 64'hB1, 1));
      vecs.push_back(mk(0, 4'b1111, 5, 4'b0100, 1, 2, 64'hC2, 1));
      vecs.push_back(mk(0, 4'b1111, 5, 4'b1000, 1, 3, 64'hD3, 1));
    end
    vecs.push_back(mk(0, 4'b0001, 5, 4'b0001, 1, 5, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b0001, 5, 4'b0000, 0, 5, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b0001, 5, 4'b0001, 1, 5, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b0001, 5, 4'b0000, 0, 5, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b1100, 5, 4'b0100, 1, 2, 64'hC2, 1));
    vecs.push_back(mk(1, 4'b1100, 5, 4'b0000, 0, 0, 64'h00, 0));
    vecs.push_back(mk(0, 4'b1100, 5, 4'b0100, 1, 2, 64'hC2, 1));
    vecs.push_back(mk(0, 4'b1100, 5, 4'b1000, 1, 3, 64'hD3, 1));
    vecs.push_back(mk(0, 4'b0000, 5, 4'b0000, 0, 3, 64'hD3, 0));
    vecs.push_back(mk(1, 4'b0000, 7, 4'b0000, 0, 0, 64'h00, 0));
`ifdef REGFILE_ARB_ZERO_REG_EN
    vecs.push_back(mk(0, 4'b0001, 7, 4'b0001, 0, 0, 64'h00, 1));
    vecs.push_back(mk(0, 4'b0000, 7, 4'b0000, 0, 0, 64'h00, 0));
`else
    vecs.push_back(mk(0, 4'b0001, 7, 4'b0001, 1, 7, 64'hAA, 1));
    vecs.push_back(mk(0, 4'b0000, 7, 4'b0000, 0, 7, 64'hAA, 0));
`endif
    // Pointer must have moved past requester 0, so requester 1 wins.
    vecs.push_back(mk(0, 4'b0011, 7, 4'b0010, 1, 1, 64'hB1, 1));

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      req      = vecs[i].rq;
      req_addr = {3'd3, 3'd2, 3'd1, vecs[i].a0};
      req_data = {64'hD3, 64'hC2, 64'hB1, 64'hAA};
      @(posedge clk); #1;
      chk($sformatf("vec%0d grant", i),   64'(grant),   64'(vecs[i].e_grant));
      chk($sformatf("vec%0d wr_en", i),   64'(wr_en),   64'(vecs[i].e_en));
      chk($sformatf("vec%0d wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d wr_data", i), wr_data,      vecs[i].e_data);
      chk($sformatf("vec%0d busy", i),    64'(busy),    64'(vecs[i].e_busy));
    end

    // Randomized run; the first cycle resets both DUT and model.
    for (int c = 0; c < 600; c++) begin
      reset = (c == 0) || ($urandom_range(0, 49) == 0);
      req   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = {$urandom, $urandom};
      end
      model_step(reset, req, req_addr, req_data);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d grant", c),   64'(grant),   64'(m_grant));
      chk($sformatf("rnd%0d wr_en", c),   64'(wr_en),   64'(m_en));
      chk($sformatf("rnd%0d wr_addr", c), 64'(wr_addr), 64'(m_addr));
      chk($sformatf("rnd%0d wr_data", c), wr_data,      m_data);
      chk($sformatf("rnd%0d busy", c),    64'(busy),    64'(m_busy));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
